cacheline_adaptor: RTL and testbench
====================================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameter: LINE_W, 256, cache line width in bits.
REQ-002 Parameter: BURST_W, 64, memory burst beat width in bits; the beat count BEATS = LINE_W/BURST_W = 4.
REQ-003 Port: clk  in  1  system clock; all state changes on its rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: line_i  in  LINE_W  write line from cache.
REQ-006 Port: line_o  out  LINE_W  assembled read line to cache.
REQ-007 Port: address_i  in  32  line address from cache.
REQ-008 Port: read_i  in  1  cache line-read request.
REQ-009 Port: write_i  in  1  cache line-write request.
REQ-010 Port: resp_o  out  1  one-cycle completion pulse to cache.
REQ-011 Port: burst_i  in  BURST_W  read beat from memory.
REQ-012 Port: burst_o  out  BURST_W  write beat to memory.
REQ-013 Port: address_o  out  32  line address to memory, with bits [4:0] forced to 0.
REQ-014 Port: read_o  out  1  memory burst-read request.
REQ-015 Port: write_o  out  1  memory burst-write request.
REQ-016 Port: resp_i  in  1  memory beat-valid / beat-accepted strobe.

Function
REQ-017 The FSM SHALL have the states IDLE, READ, WRITE and DONE.
REQ-018 IDLE: read_i=1 -> latch address_i, go to READ; else write_i=1 -> latch address_i and line_i, go to WRITE.
REQ-019 IDLE: read_i and write_i both asserted -> read has priority; the write SHALL be taken after the read completes, if write_i is still held.
REQ-020 READ: read_o=1 and address_o=latched address, held until the last beat.
REQ-021 READ: each cycle with resp_i=1 SHALL store burst_i into line buffer bits [64*cnt+63 : 64*cnt], where cnt is a 2-bit beat counter that increments on that beat.
REQ-022 READ: on the 4th beat (cnt=3 and resp_i=1), go to DONE; read_o SHALL deassert in the following cycle.
REQ-023 WRITE: write_o=1 and burst_o = latched line bits [64*cnt+63 : 64*cnt]; cnt increments on each resp_i=1.
REQ-024 WRITE: the 4th accepted beat SHALL move the FSM to DONE.
REQ-025 DONE: resp_o=1 for exactly one cycle, line_o valid, then return to IDLE; no new request is accepted in DONE.
REQ-026 Latency: resp_o SHALL be asserted in the cycle after the 4th resp_i beat.
REQ-027 resp_i gaps (deasserted cycles) SHALL be tolerated without a beat being lost or duplicated.
REQ-028 resp_i asserted in IDLE or DONE SHALL be ignored.
REQ-029 cnt SHALL wrap 3->0 on the final beat and be 0 on entry to READ or WRITE.
REQ-030 line_o SHALL hold the last assembled line until the next read completes.
REQ-031 Cache inputs changing mid-transaction SHALL have no effect, because the address and line are latched.

Reset
REQ-032 rst=1 SHALL force state=IDLE, cnt=0, read_o=0, write_o=0, resp_o=0, line_o=0, burst_o=0, address_o=0 at the next clock edge.
REQ-033 Reset mid-burst SHALL abandon the transaction and emit no resp_o.

Structure
REQ-034 A shared package (mem_types_pkg) SHALL hold the LINE_W/BURST_W defaults, the BEATS constant, and the state enum type.
REQ-035 The block SHALL have no sub-modules; it is one FSM plus a counter and buffers, placed between the L2/arbiter and ParamMemory.

Verification
REQ-036 Read, line address 0x60: beats 0x11..1, 0x22..2, 0x33..3, 0x44..4 on consecutive resp_i -> line_o = {0x44..4, 0x33..3, 0x22..2, 0x11..1}; resp_o exactly 1 cycle after the 4th beat; address_o = 0x60.
REQ-037 Write of line 0xAAAA_..._0001 -> burst_o beats in order of bits [63:0] through [255:192]; write_o drops after the 4th beat; a single resp_o pulse.
REQ-038 Read with resp_i gaps (pattern 1,0,1,0,0,1,1) -> same line assembled, resp_o only after the 4th beat.
REQ-039 read_i and write_i asserted together -> read performed first, then write; two resp_o pulses.
REQ-040 rst asserted after 2 read beats -> outputs zero next cycle, no resp_o; a following clean read returns the correct line.
REQ-041 address_i = 0x1234_5677 -> address_o = 0x1234_5660.

Source files
------------

// File: rtl/mem_types_pkg.sv
// Shared memory-side types for the cache/memory path.
// Holds the default cache line and burst beat widths, the beat count per line,
// the line-adaptor state type, and a helper that aligns a byte address to a
// 32-byte line boundary.
package mem_types_pkg;

    localparam int unsigned LINE_W_DFLT  = 256;
    localparam int unsigned BURST_W_DFLT = 64;
    localparam int unsigned BEATS        = LINE_W_DFLT / BURST_W_DFLT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Clear the byte-within-line offset so memory always sees a line address.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:5], 5'b0_0000};
    endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Cache line adaptor: converts single-cycle cache line requests into
// multi-beat memory bursts (and back), sitting between the L2/arbiter and
// the burst memory.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   line_i     write line from cache (latched when a write is accepted)
//   line_o     last fully assembled read line
//   address_i  line address from cache (latched when a request is accepted)
//   read_i     cache line-read request (wins over write_i)
//   write_i    cache line-write request
//   resp_o     one-cycle completion pulse to cache
//   burst_i    read beat from memory
//   burst_o    write beat to memory
//   address_o  line-aligned address to memory
//   read_o     memory burst-read request
//   write_o    memory burst-write request
//   resp_i     memory beat-valid / beat-accepted strobe
//
// All outputs are registered; their next values are derived from the
// next-state decode so they line up with the state they belong to.
module cacheline_adaptor
    import mem_types_pkg::*;
#(
    parameter int unsigned LINE_W  = LINE_W_DFLT,
    parameter int unsigned BURST_W = BURST_W_DFLT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int unsigned      N_BEATS  = LINE_W / BURST_W;
    localparam int unsigned      CNT_W    = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e              state_r;
    state_e              state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic [31:0]         addr_r;
    logic [31:0]         addr_nxt_s;
    logic [LINE_W-1:0]   wline_r;
    logic [LINE_W-1:0]   wline_nxt_s;
    logic [LINE_W-1:0]   rbuf_r;
    logic [LINE_W-1:0]   rbuf_nxt_s;
    logic [LINE_W-1:0]   line_r;
    logic [LINE_W-1:0]   line_nxt_s;
    logic [BURST_W-1:0]  burst_r;
    logic [BURST_W-1:0]  burst_nxt_s;
    logic                read_r;
    logic                read_nxt_s;
    logic                write_r;
    logic                write_nxt_s;
    logic                resp_r;
    logic                resp_nxt_s;

    // Next-state, beat counter, buffer and registered-output decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        addr_nxt_s  = addr_r;
        wline_nxt_s = wline_r;
        rbuf_nxt_s  = rbuf_r;
        line_nxt_s  = line_r;

        case (state_r)
            IDLE: begin
                cnt_nxt_s = '0;
                // Read has priority; a held write is picked up on a later IDLE.
                if (read_i) begin
                    state_nxt_s = READ;
                    addr_nxt_s  = line_align(address_i);
                end else if (write_i) begin
                    state_nxt_s = WRITE;
                    addr_nxt_s  = line_align(address_i);
                    wline_nxt_s = line_i;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                if (resp_i) begin
                    rbuf_nxt_s[32'(cnt_r) * BURST_W +: BURST_W] = burst_i;
                    cnt_nxt_s = cnt_r + CNT_ONE;
                    // line_o only changes once a whole line has arrived.
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = DONE;
                        line_nxt_s  = rbuf_nxt_s;
                    end else begin
                        state_nxt_s = READ;
                    end
                end else begin
                    state_nxt_s = READ;
                end
            end
            WRITE: begin
                if (resp_i) begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = WRITE;
                    end
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            DONE: begin
                // Requests seen here are deliberately not accepted.
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase

        read_nxt_s  = (state_nxt_s == READ);
        write_nxt_s = (state_nxt_s == WRITE);
        resp_nxt_s  = (state_nxt_s == DONE);

        // Present the beat that memory will take on its next accept strobe.
        if (state_nxt_s == WRITE) begin
            burst_nxt_s = wline_nxt_s[32'(cnt_nxt_s) * BURST_W +: BURST_W];
        end else begin
            burst_nxt_s = '0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counter, latched request data, line buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            addr_r  <= 32'h0000_0000;
            wline_r <= '0;
            rbuf_r  <= '0;
            line_r  <= '0;
            burst_r <= '0;
            read_r  <= 1'b0;
            write_r <= 1'b0;
            resp_r  <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            addr_r  <= addr_nxt_s;
            wline_r <= wline_nxt_s;
            rbuf_r  <= rbuf_nxt_s;
            line_r  <= line_nxt_s;
            burst_r <= burst_nxt_s;
            read_r  <= read_nxt_s;
            write_r <= write_nxt_s;
            resp_r  <= resp_nxt_s;
        end
    end

    assign line_o    = line_r;
    assign burst_o   = burst_r;
    assign address_o = addr_r;
    assign read_o    = read_r;
    assign write_o   = write_r;
    assign resp_o    = resp_r;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: a transaction-level model
// predicts every output each cycle, plus directed scenarios with literal
// expectations and a randomized transaction mix.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    cacheline_adaptor #(.LINE_W(256), .BURST_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_errors   = 0;
    int resp_total = 0;
    bit cmp_en     = 1'b0;

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- transaction-level reference model ----------------
    bit           m_busy  = 1'b0;
    bit           m_wr    = 1'b0;
    bit           m_done  = 1'b0;
    int           m_beats = 0;
    logic [31:0]  m_addr  = 32'h0;
    logic [255:0] m_wline = '0;
    logic [255:0] m_rline = '0;
    logic [255:0] m_line  = '0;
    logic         e_read  = 1'b0;
    logic         e_write = 1'b0;
    logic         e_resp  = 1'b0;
    logic [63:0]  e_burst = 64'h0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_beats = 0;
            m_addr = 32'h0; m_line = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (!m_busy) begin
            if (read_i || write_i) begin
                m_busy  = 1'b1;
                m_wr    = !read_i;
                m_beats = 0;
                m_addr  = (address_i / 32'd32) * 32'd32;
                if (m_wr) m_wline = line_i;
            end
        end else if (resp_i) begin
            if (!m_wr) m_rline[m_beats*64 +: 64] = burst_i;
            m_beats++;
            if (m_beats == 4) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                if (!m_wr) m_line = m_rline;
            end
        end
        e_read  = m_busy && !m_wr;
        e_write = m_busy && m_wr;
        e_resp  = m_done;
        e_burst = e_write ? m_wline[m_beats*64 +: 64] : 64'h0;
    end

    // Compare process: every cycle, on the falling edge.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("read_o",    256'(read_o),    256'(e_read));
            chk("write_o",   256'(write_o),   256'(e_write));
            chk("resp_o",    256'(resp_o),    256'(e_resp));
            chk("burst_o",   256'(burst_o),   256'(e_burst));
            chk("address_o", 256'(address_o), 256'(m_addr));
            chk("line_o",    line_o,          m_line);
            if (resp_o === 1'b1) resp_total++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One cache request; memory supplies 4 beats with gaps from a fixed
    // pattern (pat_len > 0) or at random with gap_pct percent idle cycles.
    task automatic run_txn(input bit rd, input logic [31:0] addr, input logic [255:0] wl,
                           input logic [255:0] rl, input logic [15:0] pat, input int pat_len,
                           input int gap_pct, output logic [255:0] cap_burst,
                           output logic [31:0] cap_addr);
        int  k;
        int  t;
        int  r0;
        bit  r;
        r0        = resp_total;
        cap_burst = '0;
        read_i    = rd;
        write_i   = !rd;
        address_i = addr;
        line_i    = wl;
        step();
        read_i    = 1'b0;
        write_i   = 1'b0;
        address_i = $urandom;
        line_i    = rnd256();
        cap_addr  = address_o;
        k = 0;
        t = 0;
        while (k < 4 && t < 200) begin
            if (pat_len > 0 && t < pat_len) r = pat[t];
            else if (pat_len > 0)           r = 1'b1;
            else                            r = (int'($urandom_range(99)) >= gap_pct);
            resp_i  = r;
            burst_i = r ? rl[k*64 +: 64] : rnd64();
            if (r) begin
                cap_burst[k*64 +: 64] = burst_o;
                k++;
            end
            step();
            t++;
        end
        chk("beat_timeout", 256'(k), 256'(4));
        resp_i  = 1'($urandom_range(1));
        burst_i = rnd64();
        chk("resp_latency", 256'(resp_total - r0), 256'(1));
        chk("req_drop", 256'({read_o, write_o}), 256'(2'b00));
        step();
        resp_i = 1'b0;
        chk("resp_single", 256'(resp_total - r0), 256'(1));
    endtask

    localparam logic [255:0] RL1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] WL1 = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
                                    64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_0001};

    initial begin
        logic [255:0] cap;
        logic [255:0] rl;
        logic [255:0] wl;
        logic [255:0] wcap;
        logic [31:0]  caddr;
        logic [31:0]  a;
        bit           rd;
        int           r0;

        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        line_i = '0; address_i = 32'h0; burst_i = 64'h0;
        repeat (3) step();
        cmp_en = 1'b1;
        chk("reset_outs", 256'({read_o, write_o, resp_o, burst_o, address_o}), 256'(0));
        chk("reset_line", line_o, 256'(0));
        rst = 1'b0;
        step();

        // Plain read of line 0x60, back-to-back beats.
        run_txn(1'b1, 32'h0000_0060, rnd256(), RL1, 16'h0, 0, 0, cap, caddr);
        chk("rd_line", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        chk("rd_addr", 256'(caddr), 256'(32'h0000_0060));

        // Write: beats leave low word first; line_o untouched.
        run_txn(1'b0, 32'h0000_0240, WL1, rnd256(), 16'h0, 0, 0, cap, caddr);
        chk("wr_beat0", 256'(cap[63:0]),    256'(64'hAAAA_AAAA_AAAA_0001));
        chk("wr_beat2", 256'(cap[191:128]), 256'(64'h5555_5555_5555_5555));
        chk("wr_beats", cap, WL1);
        chk("wr_keeps_line", line_o, RL1);

        // Read with resp_i gap pattern 1,0,1,0,0,1,1.
        run_txn(1'b1, 32'h0000_0060, rnd256(), RL1, 16'h0065, 7, 0, cap, caddr);
        chk("gap_line", line_o, RL1);

        // Address alignment.
        run_txn(1'b1, 32'h1234_5677, rnd256(), rnd256(), 16'h0, 0, 30, cap, caddr);
        chk("align", 256'(caddr), 256'(32'h1234_5660));

        // Simultaneous read and write: read first, write after.
        r0 = resp_total;
        rl = rnd256();
        wl = rnd256();
        read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_0100; line_i = wl;
        step();
        read_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            resp_i = 1'b1; burst_i = rl[k*64 +: 64];
            step();
        end
        resp_i = 1'b0;
        chk("both_first_resp", 256'(resp_total - r0), 256'(1));
        step();
        step();
        write_i = 1'b0;
        line_i  = rnd256();
        chk("both_write_taken", 256'(write_o), 256'(1'b1));
        for (int k = 0; k < 4; k++) begin
            resp_i = 1'b1;
            wcap[k*64 +: 64] = burst_o;
            step();
        end
        resp_i = 1'b0;
        step();
        chk("both_two_resp", 256'(resp_total - r0), 256'(2));
        chk("both_read_line", line_o, rl);
        chk("both_write_beats", wcap, wl);

        // Reset after two read beats.
        r0 = resp_total;
        read_i = 1'b1; address_i = 32'h0000_0080;
        step();
        read_i = 1'b0;
        resp_i = 1'b1; burst_i = rnd64(); step();
        burst_i = rnd64(); step();
        rst = 1'b1; burst_i = rnd64();
        step();
        chk("rst_mid_outs", 256'({read_o, write_o, resp_o, burst_o, address_o}), 256'(0));
        chk("rst_mid_line", line_o, 256'(0));
        rst = 1'b0; resp_i = 1'b0;
        repeat (3) step();
        chk("rst_mid_no_resp", 256'(resp_total - r0), 256'(0));
        rl = rnd256();
        run_txn(1'b1, 32'h0000_0080, rnd256(), rl, 16'h0, 0, 20, cap, caddr);
        chk("rst_then_read", line_o, rl);

        // Randomized mix with stray resp_i between transactions.
        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom_range(1));
            a  = $urandom;
            rl = rnd256();
            wl = rnd256();
            run_txn(rd, a, wl, rl, 16'h0, 0, int'($urandom_range(60)), cap, caddr);
            chk("rnd_addr", 256'(caddr), 256'({a[31:5], 5'b0_0000}));
            if (rd) chk("rnd_line", line_o, rl);
            else    chk("rnd_wbeats", cap, wl);
            repeat (int'($urandom_range(3))) begin
                resp_i  = 1'($urandom_range(1));
                burst_i = rnd64();
                step();
            end
            resp_i = 1'b0;
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
